part_m: RTL and testbench

- Memory stage (M) of the five-stage MIPS pipeline, directly downstream of the execute stage.
- Contains the E/M pipeline register, word-organised data memory with byte-lane writes, load extension unit and M-stage hazard/forwarding outputs.
- Feeds the M/W register and the hazard/forwarding unit.

---
 rtl/part_m.sv | 173 +++++++++++++++++
 tb/tb_part_m.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/part_m.sv
// part_m: memory (M) stage of the five-stage MIPS pipeline.
//
// Holds the E/M pipeline register, a word-organised data memory with
// byte-lane writes, the load extension unit and the M-stage outputs used by
// the hazard/forwarding unit. The M/W register lives outside this block; the
// *_M2W outputs are same-cycle copies of the M register contents.
//
// Optional feature: define DM_DISPLAY_EN to print every committed store as
//   "<time>@<PC_M>: *<word address> <= <merged word>" (8-digit hex values).
// With the macro undefined no display code is compiled.
//
// Ports:
//   Clk, Reset          clock; synchronous active-low reset
//   ALUoutE, RD2E2M,    E-stage result, rt value, instruction, PC and
//   Instr_E2M, PC_E2M,  destination register, captured into the E/M register
//   A3E2M
//   FWD_M2              store data after W->M forwarding (replaces RD2_M)
//   M_rt_addr           Instr_M[20:16], W->M forwarding select
//   M_RFDst             destination register of the instruction in M
//   Tnew_M              1 for loads, 0 otherwise
//   M_fwd_data          ALUout_M, forward source for rs/rt
//   RD2_M               registered rt value
//   DMoutM              extended load data (combinational)
//   ALUout_M2W, Instr_M2W, PC_M2W, A3M2W  M register contents towards W
//
// Handshake: none. The stage advances every cycle; bubbles arrive as Instr=0.
module part_m #(
  parameter int DM_WORDS = 4096,
  parameter int DM_AW    = 12
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] ALUoutE,
  input  logic [31:0] RD2E2M,
  input  logic [31:0] Instr_E2M,
  input  logic [31:0] PC_E2M,
  input  logic [4:0]  A3E2M,
  input  logic [31:0] FWD_M2,
  output logic [4:0]  M_rt_addr,
  output logic [4:0]  M_RFDst,
  output logic [1:0]  Tnew_M,
  output logic [31:0] M_fwd_data,
  output logic [31:0] RD2_M,
  output logic [31:0] DMoutM,
  output logic [31:0] ALUout_M2W,
  output logic [31:0] Instr_M2W,
  output logic [31:0] PC_M2W,
  output logic [4:0]  A3M2W
);

  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_SH  = 6'b101001;
  localparam logic [5:0] OP_SB  = 6'b101000;

  // E/M pipeline register
  logic [31:0] alu_m;
  logic [31:0] rd2_m;
  logic [31:0] instr_m;
  logic [31:0] pc_m;
  logic [4:0]  a3_m;

  logic [31:0] dm [DM_WORDS];

  logic [5:0]       op;
  logic             is_load;
  logic             is_store;
  logic [DM_AW-1:0] word_idx;
  logic [31:0]      rd_word;
  logic [3:0]       wmask;
  logic [31:0]      wdata;
  logic [31:0]      merged_word;
  logic [15:0]      half_sel;
  logic [7:0]       byte_sel;

  assign op       = instr_m[31:26];
  // Upper address bits are dropped, so addresses alias modulo the memory size.
  assign word_idx = alu_m[DM_AW+1:2];
  assign rd_word  = dm[word_idx];

  always_comb begin
    is_load  = 1'b0;
    is_store = 1'b0;
    case (op)
      OP_LW, OP_LH, OP_LHU, OP_LB, OP_LBU: is_load  = 1'b1;
      OP_SW, OP_SH, OP_SB:                 is_store = 1'b1;
      default: ;
    endcase
  end

  // Lane enables and lane-replicated store data
  always_comb begin
    wmask = 4'b0000;
    wdata = FWD_M2;
    case (op)
      OP_SW: wmask = 4'b1111;
      OP_SH: begin
        wmask = alu_m[1] ? 4'b1100 : 4'b0011;
        wdata = {2{FWD_M2[15:0]}};
      end
      OP_SB: begin
        wmask = 4'b0001 << alu_m[1:0];
        wdata = {4{FWD_M2[7:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    merged_word = rd_word;
    for (int i = 0; i < 4; i++) begin
      if (wmask[i]) merged_word[8*i +: 8] = wdata[8*i +: 8];
    end
  end

  // Load extension reads the pre-write word (asynchronous read)
  assign half_sel = alu_m[1] ? rd_word[31:16] : rd_word[15:0];
  assign byte_sel = rd_word[8*alu_m[1:0] +: 8];

  always_comb begin
    DMoutM = 32'h0;
    case (op)
      OP_LW:  DMoutM = rd_word;
      OP_LH:  DMoutM = {{16{half_sel[15]}}, half_sel};
      OP_LHU: DMoutM = {16'h0, half_sel};
      OP_LB:  DMoutM = {{24{byte_sel[7]}}, byte_sel};
      OP_LBU: DMoutM = {24'h0, byte_sel};
      default: ;
    endcase
  end

  // Reset has priority over a store sitting in M.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      alu_m   <= '0;
      rd2_m   <= '0;
      instr_m <= '0;
      pc_m    <= '0;
      a3_m    <= '0;
      for (int i = 0; i < DM_WORDS; i++) dm[i] <= '0;
    end else begin
      alu_m   <= ALUoutE;
      rd2_m   <= RD2E2M;
      instr_m <= Instr_E2M;
      pc_m    <= PC_E2M;
      a3_m    <= A3E2M;
      if (is_store) dm[word_idx] <= merged_word;
    end
  end

`ifdef DM_DISPLAY_EN
  always_ff @(posedge Clk) begin
    if (Reset && is_store)
      $display("%0t@%08h: *%08h <= %08h", $time, pc_m, {alu_m[31:2], 2'b00}, merged_word);
  end
`else
`endif

  assign M_rt_addr  = instr_m[20:16];
  assign M_RFDst    = a3_m;
  assign Tnew_M     = {1'b0, is_load};
  assign M_fwd_data = alu_m;
  assign RD2_M      = rd2_m;
  assign ALUout_M2W = alu_m;
  assign Instr_M2W  = instr_m;
  assign PC_M2W     = pc_m;
  assign A3M2W      = a3_m;

endmodule

// File: tb/tb_part_m.sv
// Directed bench for part_m. Each issue() places one instruction into the
// E/M register; checks run #1 after that edge while it sits in M. A store in
// M commits at the following edge, i.e. when the next issue() happens.
module tb_part_m;

  logic        Clk;
  logic        Reset;
  logic [31:0] ALUoutE, RD2E2M, Instr_E2M, PC_E2M, FWD_M2;
  logic [4:0]  A3E2M;
  logic [4:0]  M_rt_addr, M_RFDst, A3M2W;
  logic [1:0]  Tnew_M;
  logic [31:0] M_fwd_data, RD2_M, DMoutM, ALUout_M2W, Instr_M2W, PC_M2W;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [5:0] OP_NOP = 6'b000000;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_SH  = 6'b101001;
  localparam logic [5:0] OP_SB  = 6'b101000;

  part_m dut (
    .Clk(Clk), .Reset(Reset),
    .ALUoutE(ALUoutE), .RD2E2M(RD2E2M), .Instr_E2M(Instr_E2M),
    .PC_E2M(PC_E2M), .A3E2M(A3E2M), .FWD_M2(FWD_M2),
    .M_rt_addr(M_rt_addr), .M_RFDst(M_RFDst), .Tnew_M(Tnew_M),
    .M_fwd_data(M_fwd_data), .RD2_M(RD2_M), .DMoutM(DMoutM),
    .ALUout_M2W(ALUout_M2W), .Instr_M2W(Instr_M2W), .PC_M2W(PC_M2W),
    .A3M2W(A3M2W)
  );

  // clock / reset
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic [31:0] pc_ctr = 32'h0000_3000;

  // driver: present one instruction in E, clock it into M, then drive FWD_M2
  task automatic issue(input logic [5:0] op, input logic [31:0] addr,
                       input logic [31:0] rd2, input logic [4:0] a3,
                       input logic [31:0] fwd);
    @(negedge Clk);
    ALUoutE   = addr;
    RD2E2M    = rd2;
    Instr_E2M = {op, 5'd0, a3, 16'd0};
    PC_E2M    = pc_ctr;
    A3E2M     = a3;
    pc_ctr    = pc_ctr + 4;
    @(posedge Clk);
    #1;
    FWD_M2 = fwd;
  endtask

  task automatic test_reset();
    Reset = 1'b0;
    ALUoutE = 32'hFFFF_FFFF; RD2E2M = 32'hFFFF_FFFF; Instr_E2M = {OP_LW, 26'h3FF_FFFF};
    PC_E2M = 32'hFFFF_FFFF; A3E2M = 5'd31; FWD_M2 = 32'h0;
    @(posedge Clk); #1;
    n_checks++; if (DMoutM !== 32'h0) begin n_fail++; $display("FAIL rst_dmout got %h exp %h", DMoutM, 32'h0); end
    n_checks++; if (Tnew_M !== 2'd0) begin n_fail++; $display("FAIL rst_tnew got %0d exp 0", Tnew_M); end
    n_checks++; if (ALUout_M2W !== 32'h0) begin n_fail++; $display("FAIL rst_alu got %h exp %h", ALUout_M2W, 32'h0); end
    n_checks++; if (Instr_M2W !== 32'h0) begin n_fail++; $display("FAIL rst_instr got %h exp %h", Instr_M2W, 32'h0); end
    @(negedge Clk);
    Reset = 1'b1;
    issue(OP_NOP, 32'h0, 32'h0, 5'd0, 32'h0);
    n_checks++; if (DMoutM !== 32'h0) begin n_fail++; $display("FAIL nop_dmout got %h exp %h", DMoutM, 32'h0); end
    n_checks++; if (Tnew_M !== 2'd0) begin n_fail++; $display("FAIL nop_tnew got %0d exp 0", Tnew_M); end
    issue(OP_LW, 32'h0, 32'h0, 5'd2, 32'h0);
    n_checks++; if (DMoutM !== 32'h0) begin n_fail++; $display("FAIL lw0 got %h exp %h", DMoutM, 32'h0); end
  endtask

  task automatic test_sw_lw();
    issue(OP_SW, 32'h10, 32'h0, 5'd3, 32'h1234_5678);
    issue(OP_LW, 32'h10, 32'h0, 5'd4, 32'h0);
    n_checks++; if (DMoutM !== 32'h1234_5678) begin n_fail++; $display("FAIL sw_lw got %h exp %h", DMoutM, 32'h1234_5678); end
    // addr[1:0] ignored by sw
    issue(OP_SW, 32'h43, 32'h0, 5'd3, 32'h1122_3344);
    issue(OP_LW, 32'h40, 32'h0, 5'd4, 32'h0);
    n_checks++; if (DMoutM !== 32'h1122_3344) begin n_fail++; $display("FAIL sw_unaligned got %h exp %h", DMoutM, 32'h1122_3344); end
  endtask

  task automatic test_byte();
    issue(OP_SB, 32'h13, 32'h0, 5'd3, 32'hFFFF_FFAB);
    issue(OP_LW, 32'h10, 32'h0, 5'd4, 32'h0);
    n_checks++; if (DMoutM !== 32'hAB34_5678) begin n_fail++; $display("FAIL sb_word got %h exp %h", DMoutM, 32'hAB34_5678); end
    issue(OP_LB, 32'h13, 32'h0, 5'd4, 32'h0);
    n_checks++; if (DMoutM !== 32'hFFFF_FFAB) begin n_fail++; $display("FAIL lb13 got %h exp %h", DMoutM, 32'hFFFF_FFAB); end
    issue(OP_LBU, 32'h13, 32'h0, 5'd4, 32'h0);
    n_checks++; if (DMoutM !== 32'h0000_00AB) begin n_fail++; $display("FAIL lbu13 got %h exp %h", DMoutM, 32'h0000_00AB); end
    issue(OP_LB, 32'h11, 32'h0, 5'd4, 32'h0);
    n_checks++; if (DMoutM !== 32'h0000_0056) begin n_fail++; $display("FAIL lb11 got %h exp %h", DMoutM, 32'h0000_0056); end
  endtask

  task automatic test_half();
    issue(OP_SW, 32'h10, 32'h0, 5'd3, 32'h1234_5678);
    issue(OP_SH, 32'h12, 32'h0, 5'd3, 32'hFFFF_8001);
    issue(OP_LW, 32'h10, 32'h0, 5'd4, 32'h0);
    n_checks++; if (DMoutM !== 32'h8001_5678) begin n_fail++; $display("FAIL sh_word got %h exp %h", DMoutM, 32'h8001_5678); end
    issue(OP_LH, 32'h12, 32'h0, 5'd4, 32'h0);
    n_checks++; if (DMoutM !== 32'hFFFF_8001) begin n_fail++; $display("FAIL lh12 got %h exp %h", DMoutM, 32'hFFFF_8001); end
    issue(OP_LHU, 32'h10, 32'h0, 5'd4, 32'h0);
    n_checks++; if (DMoutM !== 32'h0000_5678) begin n_fail++; $display("FAIL lhu10 got %h exp %h", DMoutM, 32'h0000_5678); end
    issue(OP_LHU, 32'h12, 32'h0, 5'd4, 32'h0);
    n_checks++; if (DMoutM !== 32'h0000_8001) begin n_fail++; $display("FAIL lhu12 got %h exp %h", DMoutM, 32'h0000_8001); end
    // low half, addr[0] ignored
    issue(OP_SH, 32'h11, 32'h0, 5'd3, 32'h0000_9ABC);
    issue(OP_LW, 32'h10, 32'h0, 5'd4, 32'h0);
    n_checks++; if (DMoutM !== 32'h8001_9ABC) begin n_fail++; $display("FAIL sh_low got %h exp %h", DMoutM, 32'h8001_9ABC); end
  endtask

  task automatic test_fwd();
    issue(OP_SW, 32'h30, 32'h0000_0001, 5'd3, 32'h0000_0055);
    n_checks++; if (RD2_M !== 32'h1) begin n_fail++; $display("FAIL rd2_m got %h exp %h", RD2_M, 32'h1); end
    n_checks++; if (Tnew_M !== 2'd0) begin n_fail++; $display("FAIL sw_tnew got %0d exp 0", Tnew_M); end
    n_checks++; if (M_rt_addr !== 5'd3) begin n_fail++; $display("FAIL sw_rt got %0d exp 3", M_rt_addr); end
    issue(OP_LW, 32'h30, 32'h0, 5'd7, 32'h0);
    n_checks++; if (DMoutM !== 32'h0000_0055) begin n_fail++; $display("FAIL fwd_data got %h exp %h", DMoutM, 32'h55); end
    n_checks++; if (Tnew_M !== 2'd1) begin n_fail++; $display("FAIL lw_tnew got %0d exp 1", Tnew_M); end
    n_checks++; if (M_RFDst !== 5'd7) begin n_fail++; $display("FAIL lw_dst got %0d exp 7", M_RFDst); end
    n_checks++; if (A3M2W !== 5'd7) begin n_fail++; $display("FAIL lw_a3w got %0d exp 7", A3M2W); end
    n_checks++; if (M_fwd_data !== 32'h30) begin n_fail++; $display("FAIL lw_fwd got %h exp %h", M_fwd_data, 32'h30); end
    n_checks++; if (PC_M2W !== pc_ctr - 4) begin n_fail++; $display("FAIL lw_pc got %h exp %h", PC_M2W, pc_ctr - 4); end
    n_checks++; if (Instr_M2W !== {OP_LW, 5'd0, 5'd7, 16'd0}) begin n_fail++; $display("FAIL lw_instr got %h exp %h", Instr_M2W, {OP_LW, 5'd0, 5'd7, 16'd0}); end
    // non-memory opcode with an address that holds data
    issue(OP_NOP, 32'h30, 32'h0, 5'd5, 32'h0);
    n_checks++; if (DMoutM !== 32'h0) begin n_fail++; $display("FAIL nonload got %h exp %h", DMoutM, 32'h0); end
  endtask

  task automatic test_reset_store();
    issue(OP_SW, 32'h20, 32'h0, 5'd3, 32'hDEAD_BEEF);
    @(negedge Clk);
    Reset = 1'b0;
    Instr_E2M = 32'h0; ALUoutE = 32'h0; A3E2M = 5'd0;
    @(posedge Clk); #1;
    n_checks++; if (Instr_M2W !== 32'h0) begin n_fail++; $display("FAIL rst2_instr got %h exp %h", Instr_M2W, 32'h0); end
    @(negedge Clk);
    Reset = 1'b1;
    issue(OP_LW, 32'h20, 32'h0, 5'd4, 32'h0);
    n_checks++; if (DMoutM !== 32'h0) begin n_fail++; $display("FAIL rst_sw got %h exp %h", DMoutM, 32'h0); end
    issue(OP_LW, 32'h30, 32'h0, 5'd4, 32'h0);
    n_checks++; if (DMoutM !== 32'h0) begin n_fail++; $display("FAIL rst_clear got %h exp %h", DMoutM, 32'h0); end
  endtask

  task automatic test_alias();
    issue(OP_SW, 32'h4000, 32'h0, 5'd3, 32'hCAFE_F00D);
    issue(OP_LW, 32'h0, 32'h0, 5'd4, 32'h0);
    n_checks++; if (DMoutM !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL alias got %h exp %h", DMoutM, 32'hCAFE_F00D); end
  endtask

  task automatic test_back_to_back();
    // consecutive stores to adjacent bytes, then read back the word
    issue(OP_SB, 32'h50, 32'h0, 5'd3, 32'h11);
    issue(OP_SB, 32'h51, 32'h0, 5'd3, 32'h22);
    issue(OP_SB, 32'h52, 32'h0, 5'd3, 32'h33);
    issue(OP_SB, 32'h53, 32'h0, 5'd3, 32'h84);
    issue(OP_LW, 32'h50, 32'h0, 5'd4, 32'h0);
    n_checks++; if (DMoutM !== 32'h8433_2211) begin n_fail++; $display("FAIL b2b_word got %h exp %h", DMoutM, 32'h8433_2211); end
    issue(OP_LH, 32'h52, 32'h0, 5'd4, 32'h0);
    n_checks++; if (DMoutM !== 32'hFFFF_8433) begin n_fail++; $display("FAIL b2b_lh got %h exp %h", DMoutM, 32'hFFFF_8433); end
  endtask

  initial begin
    test_reset();
    test_sw_lw();
    test_byte();
    test_half();
    test_fwd();
    test_reset_store();
    test_alias();
    test_back_to_back();
    issue(OP_NOP, 32'h0, 32'h0, 5'd0, 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
